// File: rtl/bitdet_pkg.sv
// Shared constants and types for the serial bit-pattern detector.
//
// Contents:
//   DEF_PAT_W    default pattern length in bits
//   DEF_PATTERN  default pattern (MSB is the first bit received)
//   DEF_CNT_W    default match counter width
//   fill_state_e fill-level state: EMPTY / FILLING / PRIMED
package bitdet_pkg;

  localparam int          DEF_PAT_W   = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b1011;
  localparam int          DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    PRIMED  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/bitdet_sat_counter.sv
// Saturating up-counter used to count pattern matches.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (count -> 0)
//   inc    increment request; ignored once the count is all-ones
//   clear  synchronous clear, wins over inc
//   count  current count value
module bitdet_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bit_pattern_detector.sv
// Serial bit-stream pattern detector. Each valid input bit is appended to a
// short history; when the history plus the current bit equal PATTERN a
// same-cycle (Mealy) match pulse is raised on `out`, registered onto `out_q`,
// and counted in a saturating counter.
//
// Handshake: `in_valid` qualifies `in`. There is no ready/backpressure; a
// bit is consumed on every rising edge where in_valid=1.
//
// Build option: define BITDET_NONOVERLAP_EN to make detection
// non-overlapping (history and fill are flushed on every match). Without
// it, detection is overlapping.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   in          serial data bit
//   in_valid    `in` is sampled only when high
//   clear       synchronous clear of history, fill, counter and out_q
//   out         Mealy match pulse
//   out_q       `out` registered one cycle later
//   match_cnt   saturating match count
//   fill        number of valid history bits held (0..PAT_W-1)
//   fill_state  debug view of the fill-level state (EMPTY/FILLING/PRIMED)
module bit_pattern_detector
  import bitdet_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in,
  input  logic                   in_valid,
  input  logic                   clear,
  output logic                   out,
  output logic                   out_q,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [$clog2(PAT_W):0] fill,
  output fill_state_e            fill_state
);

  localparam int FILL_W = $clog2(PAT_W) + 1;
  localparam int HIST_W = PAT_W - 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [HIST_W-1:0] hist, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_r, fill_d;
  logic              match;
  logic              primed;

  // Newest bit enters at bit 0; a 2-bit pattern keeps only one history bit.
  if (HIST_W == 1) begin : g_hist1
    assign hist_shift = in;
  end else begin : g_histn
    assign hist_shift = {hist[HIST_W-2:0], in};
  end

  assign primed = (fill_r == FILL_MAX);
  assign match  = in_valid && primed && ({hist, in} == PATTERN);

  // Next-state and output logic.
  always_comb begin
    hist_d     = hist;
    fill_d     = fill_r;
    out        = 1'b0;
    fill_state = EMPTY;

    if (fill_r == '0) begin
      fill_state = EMPTY;
    end else if (primed) begin
      fill_state = PRIMED;
    end else begin
      fill_state = FILLING;
    end

    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      out = match;
`ifdef BITDET_NONOVERLAP_EN
      if (match) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = primed ? fill_r : fill_r + 1'b1;
      end
`else
      hist_d = hist_shift;
      fill_d = primed ? fill_r : fill_r + 1'b1;
`endif
    end
  end

  // State register. `out` is already gated by clear, so out_q needs no
  // separate clear term.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist   <= '0;
      fill_r <= '0;
      out_q  <= 1'b0;
    end else begin
      hist   <= hist_d;
      fill_r <= fill_d;
      out_q  <= out;
    end
  end

  assign fill = fill_r;

  bitdet_sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out),
    .clear (clear),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_bit_pattern_detector.sv
module tb_bit_pattern_detector;
  import bitdet_pkg::*;

  localparam int               PAT_W   = 4;
  localparam int               CNT_W   = 8;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
  localparam int               FILL_W  = $clog2(PAT_W) + 1;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

`ifdef BITDET_NONOVERLAP_EN
  localparam bit NONOVL   = 1'b1;
  localparam int TBL_CNT  = 1;
`else
  localparam bit NONOVL   = 1'b0;
  localparam int TBL_CNT  = 2;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in = 1'b0;
  logic               in_valid = 1'b0;
  logic               clear = 1'b0;
  logic               out, out_q;
  logic [CNT_W-1:0]   match_cnt;
  logic [FILL_W-1:0]  fill;
  fill_state_e        fill_state;

  always #5 clk = ~clk;

  bit_pattern_detector #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .clear      (clear),
    .out        (out),
    .out_q      (out_q),
    .match_cnt  (match_cnt),
    .fill       (fill),
    .fill_state (fill_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  bit         hist_q[$];   // valid bits since last reset/clear, oldest first
  int         m_cnt = 0;
  logic [0:0] exp_q[$];    // expected out_q values, one per elapsed cycle

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Window = last PAT_W-1 stored bits followed by the current bit, read in
  // arrival order; the first-arrived bit is the pattern MSB.
  function automatic bit model_match(input bit b, input bit v, input bit c);
    logic [PAT_W-1:0] w;
    int base;
    if (!v || c || hist_q.size() < PAT_W - 1) return 1'b0;
    base = hist_q.size() - (PAT_W - 1);
    for (int i = 0; i < PAT_W - 1; i++) w[PAT_W-1-i] = hist_q[base+i];
    w[0] = b;
    return (w == PATTERN);
  endfunction

  function automatic int model_state();
    if (hist_q.size() == 0) return int'(EMPTY);
    if (hist_q.size() < PAT_W - 1) return int'(FILLING);
    return int'(PRIMED);
  endfunction

  task automatic model_update(input bit b, input bit v, input bit c, input bit m);
    if (c) begin
      hist_q.delete();
      m_cnt = 0;
    end else if (v) begin
      if (m && NONOVL) begin
        hist_q.delete();
      end else begin
        hist_q.push_back(b);
        if (hist_q.size() > PAT_W - 1) void'(hist_q.pop_front());
      end
      if (m && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; drives, checks mid-cycle, returns #1 after
  // the next rising edge. `o` is the DUT's out as sampled in this cycle.
  task automatic cycle(input bit b, input bit v, input bit c, output bit o);
    bit         m;
    logic [0:0] eq;
    in = b; in_valid = v; clear = c;
    #2;
    m  = model_match(b, v, c);
    eq = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    o  = out;
    chk("out",        32'(out),        32'(m));
    chk("out_q",      32'(out_q),      32'(eq));
    chk("match_cnt",  32'(match_cnt),  32'(m_cnt));
    chk("fill",       32'(fill),       32'(hist_q.size()));
    chk("fill_state", 32'(fill_state), 32'(model_state()));
    model_update(b, v, c, m);
    exp_q.push_back(m);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bit o;
    cycle(1'b0, 1'b0, 1'b0, o);
  endtask

  task automatic do_clear();
    bit o;
    cycle(1'b0, 1'b0, 1'b1, o);
  endtask

  // Reset applied away from the clock edge while the input looks active.
  task automatic do_reset();
    in = 1'b1; in_valid = 1'b1; clear = 1'b0;
    reset = 1'b0;
    #2;
    chk("rst_out",   32'(out),       0);
    chk("rst_out_q", 32'(out_q),     0);
    chk("rst_cnt",   32'(match_cnt), 0);
    chk("rst_fill",  32'(fill),      0);
    hist_q.delete();
    m_cnt = 0;
    exp_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
  endtask

  typedef struct {
    bit b;
    bit exp_out;
  } vec_t;

  vec_t vt[7];

  initial begin
    bit o;
    int n_out;

    // initial reset
    do_reset();
    idle();

    // Table: 1,0,1,1,0,1,1 -> matches on bits 4 and 7 (bit 7 only overlapping)
    vt[0] = '{1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0};
    vt[6] = '{1'b1, !NONOVL};
    for (int i = 0; i < 7; i++) begin
      cycle(vt[i].b, 1'b1, 1'b0, o);
      chk($sformatf("tbl_out[%0d]", i), 32'(o), 32'(vt[i].exp_out));
    end
    idle();
    chk("tbl_cnt",  32'(match_cnt), TBL_CNT);
    chk("tbl_fill", 32'(fill),      PAT_W - 1);

    // Alternating upstream stream never matches
    do_clear();
    n_out = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(bit'(i % 2), 1'b1, 1'b0, o);
      n_out += int'(o);
    end
    idle();
    chk("alt_pulses", 32'(n_out),     0);
    chk("alt_cnt",    32'(match_cnt), 0);

    // 1,0,1 then a gap of 5 invalid cycles, then 1 -> single match
    do_clear();
    cycle(1'b1, 1'b1, 1'b0, o);
    cycle(1'b0, 1'b1, 1'b0, o);
    cycle(1'b1, 1'b1, 1'b0, o);
    for (int i = 0; i < 5; i++) begin
      cycle(bit'($urandom_range(0, 1)), 1'b0, 1'b0, o);
      chk("gap_out", 32'(o), 0);
    end
    cycle(1'b1, 1'b1, 1'b0, o);
    chk("gap_match",   32'(o),     1);
    chk("gap_out_q",   32'(out_q), 1);
    idle();
    chk("gap_cnt",     32'(match_cnt), 1);

    // Clear during a matching bit: not counted, not reported on out_q
    do_clear();
    for (int i = 0; i < 4; i++) cycle(PATTERN[PAT_W-1-i], 1'b1, 1'b0, o);
    cycle(1'b1, 1'b1, 1'b0, o);
    cycle(1'b0, 1'b1, 1'b0, o);
    cycle(1'b1, 1'b1, 1'b0, o);
    chk("pre_clr_cnt", 32'(match_cnt), 1);
    cycle(1'b1, 1'b1, 1'b1, o);
    chk("clr_out",   32'(o),         0);
    chk("clr_out_q", 32'(out_q),     0);
    chk("clr_fill",  32'(fill),      0);
    chk("clr_cnt",   32'(match_cnt), 0);

    // Reset mid-stream discards partial history
    cycle(1'b1, 1'b1, 1'b0, o);
    cycle(1'b0, 1'b1, 1'b0, o);
    cycle(1'b1, 1'b1, 1'b0, o);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, o);
    chk("post_rst_b1", 32'(o), 0);
    cycle(1'b0, 1'b1, 1'b0, o);
    cycle(1'b1, 1'b1, 1'b0, o);
    chk("post_rst_b3", 32'(o), 0);
    cycle(1'b1, 1'b1, 1'b0, o);
    chk("post_rst_b4", 32'(o), 1);

    // Saturation: 300 matches, counter holds at max while out keeps pulsing
    do_clear();
    n_out = 0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < PAT_W; i++) begin
        cycle(PATTERN[PAT_W-1-i], 1'b1, 1'b0, o);
        n_out += int'(o);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, o);
    chk("sat_pulses", 32'(n_out),     300);
    chk("sat_out_q",  32'(out_q),     0);
    chk("sat_cnt",    32'(match_cnt), CNT_MAX);

    // Randomized stream against the model
    do_clear();
    for (int i = 0; i < 2000; i++) begin
      cycle(bit'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 49) == 0), o);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bit_pattern_detector.md
# bit_pattern_detector

Serial bit-stream pattern detector that sits directly downstream of the toggling Mealy state machine and consumes its one-bit `out` stream. Each valid input bit is compared against a fixed PAT_W-bit pattern. The block raises a same-cycle Mealy match pulse and a registered copy of it, and keeps a saturating count of matches for status readback.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- PATTERN, 4'b1011, pattern to detect; MSB is the first bit received
- CNT_W, 8, match counter width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; all state clears while low
- in  input  1  serial data bit (upstream FSM output)
- in_valid  input  1  `in` is sampled only when high
- clear  input  1  synchronous clear of history, fill and counter
- out  output  1  Mealy match pulse, combinational from `in`/`in_valid`/state
- out_q  output  1  `out` registered, one cycle later
- match_cnt  output  CNT_W  saturating count of matches
- fill  output  $clog2(PAT_W)+1  number of valid history bits held (0..PAT_W-1)

## Operation
- History register `hist[PAT_W-2:0]` holds the most recent valid bits, newest in bit 0.
- On a clock edge with in_valid=1: `hist <= {hist[PAT_W-3:0], in}`; `fill` increments and saturates at PAT_W-1.
- On a clock edge with in_valid=0: no state change; `out`=0.
- Match condition: in_valid=1, fill==PAT_W-1 and {hist, in}==PATTERN. `out` is 1 for exactly that cycle.
- On a match, `match_cnt` increments and holds at 2^CNT_W-1 (no wrap).
- States follow `fill`: EMPTY (fill=0), FILLING (0<fill<PAT_W-1), PRIMED (fill=PAT_W-1). `out` can assert only in PRIMED.
- clear=1 takes priority over in_valid: hist=0, fill=0, match_cnt=0, out_q=0. `out` is forced to 0 in that cycle.
- Reset values: hist=0, fill=0, match_cnt=0, out_q=0. `out`=0 while reset is low.

## Timing
- `out` has zero latency relative to the sampled bit (Mealy). `out_q` and `match_cnt` update on the same edge, so both are visible one cycle after `out`.
- Back-to-back valid bits are accepted every cycle, with no backpressure.
- Reset asserted mid-stream discards the partial history. After reset deasserts, the first possible match is on the PAT_W-th valid bit.
- A match in the same cycle as clear is not counted and not reported on out_q.
- A counter at saturation keeps out/out_q pulsing while match_cnt holds.

## Configuration
- `BITDET_NONOVERLAP_EN` defined: on a match, fill resets to 0 and hist clears. The next match needs PAT_W fresh valid bits, so matches are non-overlapping.
- Not defined: overlapping detection; history and fill are unaffected by a match.

## Structure
- Shared package `bitdet_pkg` holds the default PAT_W, PATTERN and CNT_W constants and the fill-state enum (EMPTY/FILLING/PRIMED).
- Sub-module `bitdet_sat_counter` is a CNT_W-bit saturating counter with inc/clear and asynchronous active-low reset. Top-level holds history, fill and match logic.

## Test plan
- Reset low during activity → out=0, out_q=0, match_cnt=0, fill=0; the first match after release needs 4 valid bits.
- PATTERN=1011, valid stream 1,0,1,1,0,1,1 (overlap build) → out on bits 4 and 7; match_cnt=2.
- Same stream with BITDET_NONOVERLAP_EN → out on bit 4 only; match_cnt=1; fill=3 after bit 7.
- Upstream alternating stream 0,1,0,1,... for 32 valid cycles → out never asserts; match_cnt=0.
- Stream 1,0,1 then in_valid=0 for 5 cycles, then 1 → single match on the resumed bit; out_q high one cycle later.
- CNT_W=2 with 5 matches → match_cnt sticks at 3 while out pulses 5 times. Clear during a matching bit → no count, out_q=0, fill=0.
